// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full -- write-side controller of an asynchronous FIFO.
//
// Owns the binary/Gray write pointers and drives the dual-clock RAM write
// port. The read pointer (Gray) is brought into wclk through a 2-flop
// synchronizer, and full / almost-full / level / sticky overflow are
// produced in the write domain.
//
// Ports:
//   wclk          write-domain clock
//   wrst          synchronous reset, active-high
//   winc          write request (data presented to the RAM this cycle)
//   rptr_gray     read pointer, Gray coded, asynchronous to wclk
//   waddr         RAM write address (low ADDSIZE bits of the binary pointer)
//   wclken        RAM write enable, combinational
//   wfull         FIFO full, registered
//   wptr_gray     write pointer, Gray coded, registered
//   walmost_full  level >= DEPTH-AF_THRESH, registered
//   wlevel        pessimistic fill level 0..DEPTH, registered
//   woverflow     sticky: a write was attempted while full
module fifo_wptr_full #(
  parameter int unsigned ADDSIZE   = 8,
  parameter int unsigned AF_THRESH = 4
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic               winc,
  input  logic [ADDSIZE:0]   rptr_gray,
  output logic [ADDSIZE-1:0] waddr,
  output logic               wclken,
  output logic               wfull,
  output logic [ADDSIZE:0]   wptr_gray,
  output logic               walmost_full,
  output logic [ADDSIZE:0]   wlevel,
  output logic               woverflow
);

  localparam logic [ADDSIZE:0] AF_LEVEL = (ADDSIZE+1)'((1 << ADDSIZE) - AF_THRESH);

  logic [ADDSIZE:0] wbin_q, wbin_d;
  logic [ADDSIZE:0] wgray_q, wgray_d;
  logic [ADDSIZE:0] rq1_q, rq1_d;
  logic [ADDSIZE:0] rq2_q, rq2_d;
  logic             wfull_q, wfull_d;
  logic             walmost_full_q, walmost_full_d;
  logic [ADDSIZE:0] wlevel_q, wlevel_d;
  logic             woverflow_q, woverflow_d;

  logic             wen;
  logic [ADDSIZE:0] rbin;

  always_comb begin
    wen  = winc & ~wfull_q & ~wrst;
    rbin = '0;
    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int unsigned i = 0; i <= ADDSIZE; i++) begin
      rbin[i] = ^(rq2_q >> i);
    end

    rq1_d   = rptr_gray;
    rq2_d   = rq1_q;
    wbin_d  = wbin_q + {{ADDSIZE{1'b0}}, wen};
    wgray_d = (wbin_d >> 1) ^ wbin_d;

    // Full is evaluated on the next pointer so it asserts on the filling write.
    wfull_d        = (wgray_d == {~rq2_q[ADDSIZE:ADDSIZE-1], rq2_q[ADDSIZE-2:0]});
    wlevel_d       = wbin_d - rbin;
    walmost_full_d = (wlevel_d >= AF_LEVEL);
    woverflow_d    = woverflow_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      rq1_q          <= '0;
      rq2_q          <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      rq1_q          <= rq1_d;
      rq2_q          <= rq2_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign waddr        = wbin_q[ADDSIZE-1:0];
  assign wclken       = wen;
  assign wfull        = wfull_q;
  assign wptr_gray    = wgray_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule
